// File: rtl/tx_packet_sequencer.sv
// USB transmit packet sequencer: request checks, begin/active/gap sequencing,
// active-phase timeout and a saturating error counter.
`timescale 1ns/1ps
module tx_packet_sequencer #(
  parameter int OCC_W          = 7,
  parameter int MIN_DATA       = 1,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [2:0]           tx_packet,
  input  logic                 end_packet,
  input  logic [OCC_W-1:0]     buffer_occupancy,
  input  logic                 clear_errors,
  output logic                 tx_transfer_active,
  output logic                 begin_packet,
  output logic                 get_tx_packet_data,
  output logic [2:0]           pkt_type,
  output logic                 tx_done,
  output logic                 tx_abort,
  output logic                 tx_error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEGIN,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [2:0]       prev_pkt;
  logic [2:0]       pkt_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic new_req;
  logic is_data;
  logic illegal;
  logic too_short;
  logic req_err;
  logic accept;
  logic end_hit;
  logic tmo_hit;
  logic gap_last;

  // A request is an edge on the code, not a level.
  assign new_req   = (tx_packet != 3'd0) && (tx_packet != prev_pkt);
  assign is_data   = (tx_packet == 3'd1) || (tx_packet == 3'd2);
  assign illegal   = (tx_packet[2:1] == 2'b11);
  assign too_short = is_data && (int'(buffer_occupancy) < MIN_DATA);

  assign req_err = new_req &&
                   ((state != S_IDLE) || illegal || too_short);
  assign accept  = new_req && (state == S_IDLE) &&
                   !illegal && !too_short;

  // end_packet wins over a coincident timeout.
  assign end_hit  = (state == S_ACTIVE) && end_packet;
  assign tmo_hit  = (state == S_ACTIVE) && !end_packet &&
                    (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
  assign gap_last = (gap_cnt == GAP_LAST);

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:   if (accept) nstate = S_BEGIN;
      S_BEGIN:  nstate = S_ACTIVE;
      S_ACTIVE: if (end_hit || tmo_hit) nstate = S_GAP;
      S_GAP:    if (gap_last) nstate = S_IDLE;
      default:  nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      prev_pkt  <= '0;
      pkt_q     <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      tx_done   <= 1'b0;
      tx_abort  <= 1'b0;
      tx_error  <= 1'b0;
      err_count <= '0;
    end else begin
      state    <= nstate;
      prev_pkt <= tx_packet;
      tx_done  <= end_hit;
      tx_abort <= tmo_hit;
      tx_error <= req_err || tmo_hit;

      if (accept) begin
        pkt_q <= tx_packet;
      end else if ((state == S_GAP) && gap_last) begin
        pkt_q <= '0;
      end

      if (accept) begin
        tmo_cnt <= '0;
      end else if (state == S_ACTIVE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (state != S_GAP) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (clear_errors) begin
        err_count <= '0;
      end else if (tx_error && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  assign tx_transfer_active = (state == S_BEGIN) || (state == S_ACTIVE);
  assign begin_packet       = (state == S_BEGIN);
  assign get_tx_packet_data = (state == S_BEGIN) &&
                              ((pkt_q == 3'd1) || (pkt_q == 3'd2));
  assign pkt_type           = pkt_q;

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Bench for tx_packet_sequencer: directed stimulus with an event
// scoreboard plus direct state checks.
`timescale 1ns/1ps
module tb_tx_packet_sequencer;

  localparam int OCC_W = 7;
  localparam int ECW   = 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic [2:0]       tx_packet = 3'd0;
  logic             end_packet = 1'b0;
  logic [OCC_W-1:0] buffer_occupancy = '0;
  logic             clear_errors = 1'b0;

  logic             tx_transfer_active;
  logic             begin_packet;
  logic             get_tx_packet_data;
  logic [2:0]       pkt_type;
  logic             tx_done;
  logic             tx_abort;
  logic             tx_error;
  logic [ECW-1:0]   err_count;

  logic             z_active;
  logic             z_begin;
  logic             z_gpd;
  logic [2:0]       z_pkt;
  logic             z_done;
  logic             z_abort;
  logic             z_error;
  logic [ECW-1:0]   z_err_count;

  tx_packet_sequencer #(
    .OCC_W(OCC_W), .MIN_DATA(1), .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(8), .ERR_CNT_W(ECW)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet),
    .end_packet(end_packet), .buffer_occupancy(buffer_occupancy),
    .clear_errors(clear_errors),
    .tx_transfer_active(tx_transfer_active),
    .begin_packet(begin_packet),
    .get_tx_packet_data(get_tx_packet_data),
    .pkt_type(pkt_type), .tx_done(tx_done), .tx_abort(tx_abort),
    .tx_error(tx_error), .err_count(err_count)
  );

  // Zero-length DATA packets allowed here.
  tx_packet_sequencer #(
    .OCC_W(OCC_W), .MIN_DATA(0), .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(8), .ERR_CNT_W(ECW)
  ) u_dut_z (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet),
    .end_packet(end_packet), .buffer_occupancy(buffer_occupancy),
    .clear_errors(clear_errors),
    .tx_transfer_active(z_active),
    .begin_packet(z_begin),
    .get_tx_packet_data(z_gpd),
    .pkt_type(z_pkt), .tx_done(z_done), .tx_abort(z_abort),
    .tx_error(z_error), .err_count(z_err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_BEGIN, EV_DONE, EV_ABORT, EV_ERR} ev_t;
  typedef struct {
    ev_t        kind;
    int         at;
    logic [2:0] pkt;
    logic       gpd;
  } exp_t;

  exp_t q[$];

  task automatic expect_ev(ev_t k, int at, logic [2:0] p, logic g);
    q.push_back('{k, at, p, g});
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic match(ev_t k);
    int  idx = -1;
    logic bad = 1'b0;
    foreach (q[i]) begin
      if (idx < 0 && q[i].kind == k && q[i].at == cyc) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_%s cycle=%0d", k.name(), cyc);
    end else begin
      if (k != EV_ERR && pkt_type !== q[idx].pkt) bad = 1'b1;
      if (k == EV_BEGIN && (get_tx_packet_data !== q[idx].gpd ||
                            tx_transfer_active !== 1'b1)) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL %s_fields cycle=%0d actual pkt=%0d gpd=%0b required pkt=%0d gpd=%0b",
                 k.name(), cyc, pkt_type, get_tx_packet_data,
                 q[idx].pkt, q[idx].gpd);
      end
      q.delete(idx);
    end
  endtask

  // Scoreboard monitor: consumes expectations as pulses appear.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_%s actual=none required_cycle=%0d",
               q[0].kind.name(), q[0].at);
      q.delete(0);
    end
    if (begin_packet) match(EV_BEGIN);
    if (tx_done)      match(EV_DONE);
    if (tx_abort)     match(EV_ABORT);
    if (tx_error)     match(EV_ERR);
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    tick(3);
    check("rst_active", tx_transfer_active, 0);
    check("rst_begin", {begin_packet, get_tx_packet_data}, 0);
    check("rst_pkt", pkt_type, 0);
    check("rst_pulses", {tx_done, tx_abort, tx_error}, 0);
    check("rst_err_cnt", err_count, 0);
    check("rst_z", {z_active, z_begin, z_gpd, z_pkt, z_done,
                    z_abort, z_error, z_err_count}, 0);
    n_rst = 1'b1;
    buffer_occupancy = 7'd10;
    tick(2);

    // DATA0 path
    n = cyc;
    tx_packet = 3'd1;
    expect_ev(EV_BEGIN, n + 1, 3'd1, 1'b1);
    tick(5);
    end_packet = 1'b1;
    expect_ev(EV_DONE, n + 6, 3'd1, 1'b0);
    tick();
    end_packet = 1'b0;
    tick();
    check("gap_pkt_type", pkt_type, 1);
    check("gap_inactive", tx_transfer_active, 0);
    tick();
    check("idle_pkt_clr", pkt_type, 0);

    // ACK path, then hold code 3 in IDLE
    n = cyc;
    tx_packet = 3'd3;
    expect_ev(EV_BEGIN, n + 1, 3'd3, 1'b0);
    tick(2);
    end_packet = 1'b1;
    expect_ev(EV_DONE, n + 3, 3'd3, 1'b0);
    tick();
    end_packet = 1'b0;
    tick(6);
    check("ack_held_idle", tx_transfer_active, 0);
    tx_packet = 3'd0;
    tick();

    // Empty buffer DATA1
    buffer_occupancy = 7'd0;
    n = cyc;
    tx_packet = 3'd2;
    expect_ev(EV_ERR, n + 1, 3'd0, 1'b0);
    tick();
    check("empty_idle", tx_transfer_active, 0);
    check("zlp_accept", {z_active, z_begin, z_gpd, z_pkt}, 6'b111010);
    tick();
    check("err_cnt_1", err_count, 1);
    end_packet = 1'b1;
    tick();
    end_packet = 1'b0;
    tx_packet = 3'd0;
    tick(3);

    // Collision while ACTIVE
    buffer_occupancy = 7'd10;
    n = cyc;
    tx_packet = 3'd1;
    expect_ev(EV_BEGIN, n + 1, 3'd1, 1'b1);
    tick(2);
    tx_packet = 3'd4;
    expect_ev(EV_ERR, n + 3, 3'd0, 1'b0);
    tick();
    check("collide_active", tx_transfer_active, 1);
    end_packet = 1'b1;
    expect_ev(EV_DONE, n + 4, 3'd1, 1'b0);
    tick();
    end_packet = 1'b0;
    check("err_cnt_2", err_count, 2);
    tick(2);

    // Illegal code in IDLE
    n = cyc;
    tx_packet = 3'd7;
    expect_ev(EV_ERR, n + 1, 3'd0, 1'b0);
    tick();
    check("illegal_idle", tx_transfer_active, 0);
    tick();
    check("err_cnt_3", err_count, 3);
    tx_packet = 3'd0;
    tick();

    // Timeout after 8 ACTIVE cycles
    n = cyc;
    tx_packet = 3'd5;
    expect_ev(EV_BEGIN, n + 1, 3'd5, 1'b0);
    expect_ev(EV_ABORT, n + 10, 3'd5, 1'b0);
    expect_ev(EV_ERR, n + 10, 3'd0, 1'b0);
    tick(9);
    check("tmo_8th_active", tx_transfer_active, 1);
    tick();
    check("tmo_gap", tx_transfer_active, 0);
    tick();
    check("err_cnt_4", err_count, 4);
    tx_packet = 3'd0;
    tick(2);

    // end_packet on the 8th ACTIVE cycle beats timeout
    n = cyc;
    tx_packet = 3'd1;
    expect_ev(EV_BEGIN, n + 1, 3'd1, 1'b1);
    tick(9);
    end_packet = 1'b1;
    expect_ev(EV_DONE, n + 10, 3'd1, 1'b0);
    tick();
    end_packet = 1'b0;
    tick();
    check("err_cnt_still_4", err_count, 4);
    tx_packet = 3'd0;
    tick(2);

    // Reset mid-ACTIVE, code held through release
    n = cyc;
    tx_packet = 3'd2;
    expect_ev(EV_BEGIN, n + 1, 3'd2, 1'b1);
    tick(2);
    #1 n_rst = 1'b0;
    #1;
    check("arst_active", tx_transfer_active, 0);
    check("arst_begin", {begin_packet, get_tx_packet_data}, 0);
    check("arst_pkt", pkt_type, 0);
    check("arst_err_cnt", err_count, 0);
    check("arst_pulses", {tx_done, tx_abort, tx_error}, 0);
    tick();
    expect_ev(EV_BEGIN, n + 4, 3'd2, 1'b1);
    n_rst = 1'b1;
    tick(2);
    end_packet = 1'b1;
    expect_ev(EV_DONE, n + 6, 3'd2, 1'b0);
    tick();
    end_packet = 1'b0;
    tick(2);

    // 300 errors saturate an 8-bit counter
    for (int k = 0; k < 300; k++) begin
      n = cyc;
      tx_packet = (k % 2 == 1) ? 3'd7 : 3'd6;
      expect_ev(EV_ERR, n + 1, 3'd0, 1'b0);
      tick();
    end
    tx_packet = 3'd0;
    tick();
    check("err_sat", err_count, 255);

    // clear_errors beats a coincident increment
    n = cyc;
    tx_packet = 3'd7;
    expect_ev(EV_ERR, n + 1, 3'd0, 1'b0);
    tick();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("clr_prio", err_count, 0);
    tick();
    check("clr_hold", err_count, 0);
    tx_packet = 3'd0;
    tick(4);

    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_packet_sequencer.md
Name: tx_packet_sequencer

Overview:
- Parametrised USB transmit-side packet controller; generalises the single-mode TX control FSM.
- Accepts packet requests from the protocol layer, checks them against FIFO occupancy and type legality, and sequences the encoder through begin / active / inter-packet gap.
- Adds an active-phase timeout with abort, a configurable gap length and a saturating error counter.
- Sits between the protocol FSM and the TX FIFO/encoder.

Parameters:
OCC_W, 7, width of buffer_occupancy (FIFO depth up to 2^OCC_W-1 bytes)
MIN_DATA, 1, minimum occupancy for a DATA0/DATA1 request; 0 permits zero-length packets
GAP_CYCLES, 2, cycles spent in GAP after each packet (>=1)
TIMEOUT_CYCLES, 1024, max ACTIVE cycles without end_packet; 0 disables timeout
ERR_CNT_W, 8, width of err_count

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
tx_packet  input  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 illegal
end_packet  input  1  encoder reports last bit sent; sampled only in ACTIVE
buffer_occupancy  input  OCC_W  bytes in TX FIFO
clear_errors  input  1  synchronous clear of err_count
tx_transfer_active  output  1  high in BEGIN and ACTIVE
begin_packet  output  1  one-cycle pulse in BEGIN
get_tx_packet_data  output  1  one-cycle pulse in BEGIN, DATA0/DATA1 only
pkt_type  output  3  latched accepted request code, stable BEGIN through GAP
tx_done  output  1  one-cycle pulse on normal ACTIVE->GAP
tx_abort  output  1  one-cycle pulse on timeout ACTIVE->GAP
tx_error  output  1  registered one-cycle error pulse
err_count  output  ERR_CNT_W  saturating count of tx_error pulses

Behaviour:
- Reset (async, immediate, mid-packet included): state IDLE; all outputs 0; prev_tx_packet, timeout counter, gap counter and err_count cleared.
- New request: the cycle where tx_packet != 0 and tx_packet != prev_tx_packet. prev_tx_packet registers tx_packet every cycle.
- A code held constant is never re-accepted. Holding a nonzero code through reset release counts as a new request.
- States and transitions:
  - IDLE: a new, legal request moves to BEGIN next cycle and latches pkt_type.
  - BEGIN: lasts 1 cycle, then ACTIVE.
  - ACTIVE: end_packet=1 moves to GAP with tx_done. Otherwise, reaching TIMEOUT_CYCLES-th ACTIVE cycle (TIMEOUT_CYCLES!=0) moves to GAP with tx_abort.
  - GAP: lasts exactly GAP_CYCLES cycles, then IDLE; pkt_type cleared on entry to IDLE.
- Latency: request seen at cycle N gives BEGIN at N+1, ACTIVE at N+2.
- end_packet and timeout in the same cycle: end_packet wins (tx_done only).
- end_packet outside ACTIVE is ignored.
- Error conditions, evaluated on a new-request cycle (tx_error high next cycle; the request is dropped and the state is unaffected):
  - (a) state != IDLE (includes GAP)
  - (b) code 6 or 7
  - (c) code 1/2 with buffer_occupancy < MIN_DATA
- A timeout also raises tx_error, in the same cycle as tx_abort.
- err_count increments on each tx_error pulse and saturates at all-ones.
- clear_errors has priority over a simultaneous increment.
- Timeout counter resets on BEGIN entry and counts ACTIVE cycles only.

Test Plan:
- DATA0 path: occupancy=10, tx_packet 0->1 at N -> BEGIN at N+1 with begin_packet=get_tx_packet_data=1, pkt_type=1. end_packet at N+5 -> tx_done at N+6, GAP N+6..N+7, IDLE at N+8.
- ACK path: tx_packet 0->3 -> begin_packet pulses, get_tx_packet_data stays 0. Holding tx_packet=3 after return to IDLE gives no second BEGIN.
- Empty buffer: occupancy=0, tx_packet 0->2 -> tx_error=1 for one cycle, err_count=1, state stays IDLE. Same stimulus with MIN_DATA=0 is accepted.
- Collision/illegal: tx_packet 1->4 while ACTIVE -> tx_error, transfer continues. Code 7 in IDLE -> tx_error, no BEGIN.
- Timeout: TIMEOUT_CYCLES=8, no end_packet -> tx_abort and tx_error on the cycle after the 8th ACTIVE cycle. end_packet asserted on that same 8th cycle -> tx_done only.
- Reset/saturation: n_rst low mid-ACTIVE -> all outputs 0 immediately. Drive 300 errors with ERR_CNT_W=8 -> err_count=255. clear_errors -> 0.
